// File: rtl/demux1x2_stream.sv
// demux1x2_stream: registered 1-to-2 valid/ready stream demultiplexer.
// Each input beat is steered by its select bit (0 -> out1, 1 -> out2) into a
// one-entry holding register on that output, giving one cycle of latency with
// full throughput. Per-output counters tally beats delivered downstream.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    input stream
//   select                       destination of the current input beat
//   out1_valid/ready/data        output stream 1
//   out2_valid/ready/data        output stream 2
//   out1_count, out2_count       delivered-beat counters (wrapping)
module demux1x2_stream #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               select,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [DATA_W-1:0]  out1_data,
  output logic               out2_valid,
  input  logic               out2_ready,
  output logic [DATA_W-1:0]  out2_data,
  output logic [COUNT_W-1:0] out1_count,
  output logic [COUNT_W-1:0] out2_count
);

  logic in_fire;
  logic load1;
  logic load2;
  logic out1_fire;
  logic out2_fire;

  // Ready depends only on the selected output, so a stall on the other
  // output never blocks the input.
  assign in_ready  = select ? (~out2_valid | out2_ready) : (~out1_valid | out1_ready);
  assign in_fire   = in_valid & in_ready;
  assign load1     = in_fire & ~select;
  assign load2     = in_fire & select;
  assign out1_fire = out1_valid & out1_ready;
  assign out2_fire = out2_valid & out2_ready;

  // out1 holding register: a load wins over a drain, giving back-to-back flow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (out1_fire) begin
      out1_valid <= 1'b0;
    end
  end

  // out2 holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_valid <= 1'b0;
      out2_data  <= '0;
    end else if (load2) begin
      out2_valid <= 1'b1;
      out2_data  <= in_data;
    end else if (out2_fire) begin
      out2_valid <= 1'b0;
    end
  end

  // Delivered-beat counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_count <= '0;
      out2_count <= '0;
    end else begin
      if (out1_fire) out1_count <= out1_count + COUNT_W'(1);
      if (out2_fire) out2_count <= out2_count + COUNT_W'(1);
    end
  end

endmodule
